sudoku_job_scheduler: RTL and testbench
=======================================

// Module: sudoku_job_scheduler
// PURPOSE
//  Shares one SUDOKU solver among N_REQ requesters. Round-robin arbiter grants one job at a time.
//  Streams the granted requester's 81 cells into the solver, waits, then routes the 81 solved cells back.
//  Keeps the solver's in_valid protocol intact: 81 contiguous cells, idle gap between jobs.
//  Optional watchdog recovers a solver stalled in its solving state.
// PARAMETERS
//  N_REQ       2     number of requesters (2..8)
//  TIMEOUT     4096  max WAIT cycles before watchdog fires (WATCHDOG_EN only)
//  GAP_CYCLES  2     idle cycles forced between jobs (>=2, solver returns to idle)
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        async active-low reset
//  req          in   N_REQ    level request per requester
//  grant        out  N_REQ    one-hot, high LOAD..RETURN for the owning requester
//  src_valid    in   N_REQ    cell valid per requester, row-major, cell 0 first
//  src_data     in   4*N_REQ  packed cells, requester i at [4i+3:4i], 0 = empty
//  slv_in_valid out  1        to solver in_valid
//  slv_in       out  4        to solver in
//  slv_out_valid in  1        from solver out_valid
//  slv_out      in   4        from solver out
//  slv_rst_n    out  1        solver reset request, active low
//  dst_valid    out  N_REQ    one-hot solved-cell valid
//  dst_data     out  4        solved cell
//  job_done     out  N_REQ    1-cycle pulse with cell 80 of the result
//  job_err      out  N_REQ    1-cycle pulse: load gap (LOAD) or timeout (WAIT)
//  busy         out  1        state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, all outputs 0 except slv_rst_n=1. Reset mid-job discards the job.
//  FSM IDLE -> LOAD -> WAIT -> RETURN -> GAP -> IDLE.
//  IDLE: any req -> grant first requester at or after pointer (wrap), registered; go LOAD.
//  LOAD: waits for first src_valid[g]; then exactly 81 consecutive slv_in_valid cycles.
//   - slv_in_valid/slv_in registered, 1-cycle latency from src_valid/src_data.
//   - Cell count 7 bits, 0..80. src_valid[g] low after first cell: forward 0 (empty) for that cycle.
//     Count still advances. job_err[g] pulses once per job at the first gap.
//   - req[g] low before first cell: cancel, drop grant, go GAP.
//   - src_valid of non-granted requesters ignored.
//  WAIT: after cell 80 sent. Leaves on first slv_out_valid -> RETURN; that cell is already forwarded.
//  RETURN: dst_valid[g]=slv_out_valid, dst_data=slv_out, registered, 1-cycle latency.
//   - Output counter counts 81 cells. Cell 80 raises job_done[g] in the same cycle as its dst_valid.
//   - Then go GAP.
//  GAP: grant=0, GAP_CYCLES cycles, then IDLE. Pointer = g+1 mod N_REQ, updated on GAP entry.
//  slv_out_valid outside WAIT/RETURN is ignored. req changes outside IDLE affect only the next arbitration.
//  A requester holding req continuously is granted again only after all others are served.
// CONFIGURATION
//  SUDOKU_WATCHDOG_EN defined:
//   - 13-bit WAIT counter.
//   - At TIMEOUT cycles without slv_out_valid: slv_rst_n=0 for 2 cycles (registered), job_err[g] pulse, go GAP.
//   - No dst_valid is issued for the timed-out job.
//  Not defined: no counter; WAIT is unbounded; slv_rst_n tied 1.
// TESTING
//  1 Single job: req=01, 81 cells of a single-solvable puzzle -> grant=01, 81 slv_in_valid, 81 dst_valid[0], job_done[0] on cell 80.
//  2 Contention: req=11 held, pointer=0 -> jobs served 0,1,0,1. grant never 11. GAP>=2 cycles between jobs.
//  3 Load gap: src_valid[0] low on cell 40 -> slv_in cell 40=0, still 81 contiguous in_valid, job_err[0] one pulse.
//  4 Cancel: grant=10, req[1] drops before first cell -> no slv_in_valid, GAP, next grant to requester 0.
//  5 Watchdog (EN, TIMEOUT=64): unsolvable all-zero puzzle -> slv_rst_n low 2 cycles at WAIT+64, job_err pulse, next job completes correctly.
//  6 Reset during RETURN cell 30 -> all outputs 0, slv_rst_n=1, busy=0, next req granted from requester 0.

Source files
------------

// File: rtl/sudoku_job_scheduler.sv
// Round-robin scheduler sharing one sudoku solver among N_REQ requesters.
// Define SUDOKU_WATCHDOG_EN to add the WAIT-phase watchdog with solver reset.
module sudoku_job_scheduler #(
    parameter int N_REQ      = 2,
    parameter int TIMEOUT    = 4096,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    output logic [N_REQ-1:0]   grant,
    input  logic [N_REQ-1:0]   src_valid,
    input  logic [4*N_REQ-1:0] src_data,
    output logic               slv_in_valid,
    output logic [3:0]         slv_in,
    input  logic               slv_out_valid,
    input  logic [3:0]         slv_out,
    output logic               slv_rst_n,
    output logic [N_REQ-1:0]   dst_valid,
    output logic [3:0]         dst_data,
    output logic [N_REQ-1:0]   job_done,
    output logic [N_REQ-1:0]   job_err,
    output logic               busy
);
    localparam int          IW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int          GW        = $clog2(GAP_CYCLES + 1);
    localparam int unsigned NR        = N_REQ;
    localparam logic [6:0]  LAST_CELL = 7'd80;

    if (N_REQ < 2 || N_REQ > 8 || GAP_CYCLES < 2 || TIMEOUT < 2 || TIMEOUT > 8192) begin : g_bad_params
        $error("sudoku_job_scheduler: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_RETURN, S_GAP} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d, g_q, g_d, g_next, arb_idx;
    logic             arb_hit;
    int unsigned      idx;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [6:0]       cnt_q, cnt_d;
    logic             started_q, started_d, gap_seen_q, gap_seen_d;
    logic [GW-1:0]    gcnt_q, gcnt_d;
    logic             in_valid_q, in_valid_d;
    logic [3:0]       in_q, in_d, dst_q, dst_d;
    logic [N_REQ-1:0] dst_valid_q, dst_valid_d, done_q, done_d, err_q, err_d;
`ifdef SUDOKU_WATCHDOG_EN
    logic [12:0]      wcnt_q, wcnt_d;
    logic             srst_q, srst_d, hold_q, hold_d;
`endif

    // First requesting index at or after the pointer, wrapping.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NR; k++) begin
            idx = (32'(ptr_q) + k) % NR;
            if (!arb_hit && req[IW'(idx)]) begin
                arb_hit = 1'b1;
                arb_idx = IW'(idx);
            end
        end
    end

    assign g_next = (g_q == IW'(N_REQ - 1)) ? '0 : g_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        g_d         = g_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        started_d   = started_q;
        gap_seen_d  = gap_seen_q;
        gcnt_d      = gcnt_q;
        in_valid_d  = 1'b0;
        in_d        = '0;
        dst_valid_d = '0;
        dst_d       = '0;
        done_d      = '0;
        err_d       = '0;
`ifdef SUDOKU_WATCHDOG_EN
        wcnt_d      = wcnt_q;
        hold_d      = 1'b0;
        srst_d      = !hold_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_hit) begin
                    g_d              = arb_idx;
                    grant_d          = '0;
                    grant_d[arb_idx] = 1'b1;
                    cnt_d            = '0;
                    started_d        = 1'b0;
                    gap_seen_d       = 1'b0;
                    state_d          = S_LOAD;
                end
            end
            S_LOAD: begin
                // Once the first cell arrives the stream never stalls; holes become empty cells.
                if (started_q || src_valid[g_q]) begin
                    in_valid_d = 1'b1;
                    started_d  = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    if (src_valid[g_q]) begin
                        in_d = src_data[{g_q, 2'b00} +: 4];
                    end else if (!gap_seen_q) begin
                        err_d      = grant_q;
                        gap_seen_d = 1'b1;
                    end
                    if (cnt_q == LAST_CELL) begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
`ifdef SUDOKU_WATCHDOG_EN
                        wcnt_d  = '0;
`endif
                    end
                end else if (!req[g_q]) begin
                    grant_d = '0;
                    ptr_d   = g_next;
                    gcnt_d  = '0;
                    state_d = S_GAP;
                end
            end
            S_WAIT: begin
                if (slv_out_valid) begin
                    dst_valid_d = grant_q;
                    dst_d       = slv_out;
                    cnt_d       = 7'd1;
                    state_d     = S_RETURN;
                end
`ifdef SUDOKU_WATCHDOG_EN
                else if (wcnt_q == 13'(TIMEOUT - 1)) begin
                    srst_d  = 1'b0;
                    hold_d  = 1'b1;
                    err_d   = grant_q;
                    grant_d = '0;
                    ptr_d   = g_next;
                    gcnt_d  = '0;
                    state_d = S_GAP;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
`endif
            end
            S_RETURN: begin
                if (slv_out_valid) begin
                    dst_valid_d = grant_q;
                    dst_d       = slv_out;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == LAST_CELL) begin
                        done_d  = grant_q;
                        grant_d = '0;
                        ptr_d   = g_next;
                        gcnt_d  = '0;
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (gcnt_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            g_q         <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            started_q   <= 1'b0;
            gap_seen_q  <= 1'b0;
            gcnt_q      <= '0;
            in_valid_q  <= 1'b0;
            in_q        <= '0;
            dst_valid_q <= '0;
            dst_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            g_q         <= g_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            started_q   <= started_d;
            gap_seen_q  <= gap_seen_d;
            gcnt_q      <= gcnt_d;
            in_valid_q  <= in_valid_d;
            in_q        <= in_d;
            dst_valid_q <= dst_valid_d;
            dst_q       <= dst_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef SUDOKU_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
            srst_q <= 1'b1;
            hold_q <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            srst_q <= srst_d;
            hold_q <= hold_d;
        end
    end
    assign slv_rst_n = srst_q;
`else
    assign slv_rst_n = 1'b1;
`endif

    assign grant        = grant_q;
    assign slv_in_valid = in_valid_q;
    assign slv_in       = in_q;
    assign dst_valid    = dst_valid_q;
    assign dst_data     = dst_q;
    assign job_done     = done_q;
    assign job_err      = err_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_sudoku_job_scheduler.sv
// Scoreboard bench for sudoku_job_scheduler with a behavioural solver stub.
`timescale 1ns/1ps
module tb_sudoku_job_scheduler;
    localparam int N  = 2;
    localparam int TO = 64;
    localparam int EXP_IDX [5] = '{1, 0, 1, 0, 1};

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] v;
        logic       last;
    } dexp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]   req, grant, src_valid, dst_valid, job_done, job_err;
    logic [4*N-1:0] src_data;
    logic           slv_in_valid, slv_out_valid, slv_rst_n, busy;
    logic [3:0]     slv_in, slv_out, dst_data;
    logic           req_b [N];
    logic           sv_b  [N];
    logic [3:0]     sd_b  [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req[i]           = req_b[i];
            src_valid[i]     = sv_b[i];
            src_data[4*i +: 4] = sd_b[i];
        end
    end

    sudoku_job_scheduler #(.N_REQ(N), .TIMEOUT(TO), .GAP_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .grant(grant),
        .src_valid(src_valid), .src_data(src_data),
        .slv_in_valid(slv_in_valid), .slv_in(slv_in),
        .slv_out_valid(slv_out_valid), .slv_out(slv_out), .slv_rst_n(slv_rst_n),
        .dst_valid(dst_valid), .dst_data(dst_data),
        .job_done(job_done), .job_err(job_err), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int dst_cells = 0;
    int last_in_cyc = 0;
    int err_cyc = 0;
    int rst_low_start = 0;
    int rst_low_len = 0;
    logic [3:0]   exp_in [$];
    dexp_t        exp_dst [$];
    logic [N-1:0] exp_err [$];
    int           gl_idx [$];
    int           gl_low [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] sol(int i);
        int r = i / 9;
        int c = i % 9;
        return 4'(((r * 3 + r / 3 + c) % 9) + 1);
    endfunction

    function automatic logic [3:0] puzzle(int i, int seed);
        if (seed < 0) return 4'd0;
        return (((i * 7 + seed) % 3) == 0) ? sol(i) : 4'd0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_msg(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event occurred where none was expected or bound expired", name);
    endtask

    task automatic wait_grant(input int r, input logic lvl, input int budget);
        int n = 0;
        while (grant[r] !== lvl && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        if (grant[r] !== lvl) fail_msg($sformatf("wait_grant%0d_%0d", r, lvl));
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        chk(name, done_cnt, target);
    endtask

    task automatic run_job(input int r, input int seed, input int gap1, input int gap2,
                           input bit keep, input bit expect_dst);
        logic [3:0] c, f;
        dexp_t d;
        req_b[r] = 1'b1;
        wait_grant(r, 1'b0, 2000);
        wait_grant(r, 1'b1, 2000);
        if (grant[r] !== 1'b1) begin
            req_b[r] = 1'b0;
            return;
        end
        for (int i = 0; i < 81; i++) begin
            c = puzzle(i, seed);
            if (i == gap1 || i == gap2) begin
                sv_b[r] = 1'b0;
                sd_b[r] = 4'hF;
                f = 4'd0;
                if (i == gap1) exp_err.push_back(N'(1 << r));
            end else begin
                sv_b[r] = 1'b1;
                sd_b[r] = c;
                f = c;
            end
            exp_in.push_back(f);
            if (expect_dst) begin
                d.r = 4'(r);
                d.v = (f != 0) ? f : sol(i);
                d.last = (i == 80);
                exp_dst.push_back(d);
            end
            @(negedge clk);
        end
        sv_b[r] = 1'b0;
        sd_b[r] = 4'd0;
        if (!keep) req_b[r] = 1'b0;
    endtask

    // Solver stub: fills empty cells from a fixed solution; hangs on an all-empty grid.
    initial begin
        int n, ph, dly, k;
        logic [3:0] buffer [81];
        logic nz;
        slv_out_valid = 1'b0;
        slv_out = 4'd0;
        n = 0; ph = 0; dly = 0; k = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !slv_rst_n) begin
                n = 0; ph = 0;
                slv_out_valid = 1'b0;
                slv_out = 4'd0;
            end else begin
                case (ph)
                    0: if (slv_in_valid) begin
                        buffer[n] = slv_in;
                        n++;
                        if (n == 81) begin
                            nz = 1'b0;
                            for (int i = 0; i < 81; i++) nz = nz | (buffer[i] != 0);
                            ph = nz ? 1 : 3;
                            dly = 0;
                        end
                    end
                    1: begin
                        dly++;
                        if (dly == 4) begin ph = 2; k = 0; end
                    end
                    2: begin
                        slv_out_valid = 1'b1;
                        slv_out = (buffer[k] != 0) ? buffer[k] : sol(k);
                        k++;
                        if (k == 81) ph = 4;
                    end
                    4: begin
                        slv_out_valid = 1'b0;
                        slv_out = 4'd0;
                        ph = 0; n = 0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Solver-input monitor
    initial begin
        int run = 0;
        logic [3:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                run = 0;
            end else if (slv_in_valid) begin
                run++;
                last_in_cyc = cyc;
                if (exp_in.size() == 0) fail_msg("slv_in_unexpected");
                else begin
                    e = exp_in.pop_front();
                    chk("slv_in", int'(slv_in), int'(e));
                end
            end else if (run != 0) begin
                chk("in_run_len", run, 81);
                run = 0;
            end
        end
    end

    // Result monitor
    initial begin
        dexp_t d;
        forever begin
            @(negedge clk);
            if (rst_n && (dst_valid != 0 || job_done != 0)) begin
                if (exp_dst.size() == 0) fail_msg("dst_unexpected");
                else begin
                    d = exp_dst.pop_front();
                    chk("dst_valid", int'(dst_valid), 1 << d.r);
                    chk("dst_data", int'(dst_data), int'(d.v));
                    chk("job_done", int'(job_done), d.last ? (1 << d.r) : 0);
                    dst_cells++;
                    if (job_done != 0) done_cnt++;
                end
            end
        end
    end

    // Error-pulse monitor
    initial begin
        logic [N-1:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && job_err != 0) begin
                err_cyc = cyc;
                if (exp_err.size() == 0) fail_msg("job_err_unexpected");
                else begin
                    e = exp_err.pop_front();
                    chk("job_err", int'(job_err), int'(e));
                end
            end
        end
    end

    // Grant / solver-reset monitor
    initial begin
        logic [N-1:0] prev = '0;
        int lowrun = 0;
        int gi;
        bit in_low = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = '0;
                lowrun = 0;
            end else begin
                if (grant != 0) begin
                    chk("grant_onehot", $countones(grant), 1);
                    if (prev == 0) begin
                        gi = 0;
                        for (int i = 0; i < N; i++) if (grant[i]) gi = i;
                        gl_idx.push_back(gi);
                        gl_low.push_back(lowrun);
                    end
                    lowrun = 0;
                end else begin
                    lowrun++;
                end
                prev = grant;
                if (!slv_rst_n) begin
                    if (!in_low) begin
                        rst_low_start = cyc;
                        rst_low_len = 0;
                    end
                    in_low = 1'b1;
                    rst_low_len++;
                end else begin
                    in_low = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int n;
        for (int i = 0; i < N; i++) begin
            req_b[i] = 1'b0;
            sv_b[i]  = 1'b0;
            sd_b[i]  = 4'd0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_grant", int'(grant), 0);
        chk("rst_in_valid", int'(slv_in_valid), 0);
        chk("rst_dst_valid", int'(dst_valid), 0);
        chk("rst_job_done", int'(job_done), 0);
        chk("rst_job_err", int'(job_err), 0);
        chk("rst_slv_rst_n", int'(slv_rst_n), 1);
        chk("rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        gl_idx.delete();
        gl_low.delete();

        // Single job from requester 0
        run_job(0, 1, -1, -1, 1'b0, 1'b1);
        wait_done(1, "t1_done");
        chk("t1_grant_idx", (gl_idx.size() > 0) ? gl_idx[0] : -1, 0);

        // Cancel from requester 1, then contention served from requester 0
        gl_idx.delete();
        gl_low.delete();
        req_b[1] = 1'b1;
        wait_grant(1, 1'b1, 200);
        chk("cancel_grant", int'(grant), 2);
        req_b[1] = 1'b0;
        @(negedge clk); #1;
        chk("cancel_drop", int'(grant), 0);
        chk("cancel_busy", int'(busy), 1);
        fork
            begin
                run_job(0, 2, -1, -1, 1'b1, 1'b1);
                run_job(0, 3, -1, -1, 1'b0, 1'b1);
            end
            begin
                run_job(1, 4, -1, -1, 1'b1, 1'b1);
                run_job(1, 5, -1, -1, 1'b0, 1'b1);
            end
        join
        wait_done(5, "t2_done");
        chk("glog_len", gl_idx.size(), 5);
        for (int i = 0; i < 5 && i < gl_idx.size(); i++) begin
            chk($sformatf("glog_idx%0d", i), gl_idx[i], EXP_IDX[i]);
            if (i > 0) chk($sformatf("glog_gap%0d", i), gl_low[i], 3);
        end

        // Load gaps at cells 40 and 60: one error pulse, zeros forwarded
        run_job(0, 6, 40, 60, 1'b0, 1'b1);
        wait_done(6, "t3_done");
        chk("t3_err_drained", exp_err.size(), 0);

`ifdef SUDOKU_WATCHDOG_EN
        // All-empty grid hangs the stub; watchdog must reset it
        exp_err.push_back(N'(1));
        rst_low_len = 0;
        run_job(0, -1, -1, -1, 1'b0, 1'b0);
        n = 0;
        while (!(rst_low_len >= 1 && slv_rst_n) && n < 400) begin
            @(negedge clk); #1;
            n++;
        end
        chk("wd_delay", rst_low_start - last_in_cyc, TO);
        chk("wd_low_len", rst_low_len, 2);
        chk("wd_err_cyc", err_cyc, rst_low_start);
        chk("wd_err_drained", exp_err.size(), 0);
        run_job(0, 7, -1, -1, 1'b0, 1'b1);
        wait_done(7, "t5_done");
`endif

        // Reset while returning cell 30
        run_job(0, 8, -1, -1, 1'b0, 1'b1);
        n = dst_cells + 31;
        while (dst_cells < n && n - dst_cells <= 31 && cyc < 100000) begin
            @(negedge clk); #1;
            if (!busy && dst_cells < n) break;
        end
        chk("t6_cells_seen", dst_cells, n);
        rst_n = 1'b0;
        #1;
        chk("t6_grant", int'(grant), 0);
        chk("t6_in_valid", int'(slv_in_valid), 0);
        chk("t6_dst_valid", int'(dst_valid), 0);
        chk("t6_dst_data", int'(dst_data), 0);
        chk("t6_job_done", int'(job_done), 0);
        chk("t6_slv_rst_n", int'(slv_rst_n), 1);
        chk("t6_busy", int'(busy), 0);
        exp_dst.delete();
        exp_in.delete();
        exp_err.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        gl_idx.delete();
        gl_low.delete();
        done_cnt = 0;
        req_b[1] = 1'b1;
        run_job(0, 9, -1, -1, 1'b0, 1'b1);
        req_b[1] = 1'b0;
        chk("t6_post_grant", (gl_idx.size() > 0) ? gl_idx[0] : -1, 0);
        wait_done(1, "t6_done");

        repeat (10) @(negedge clk);
        chk("left_in", exp_in.size(), 0);
        chk("left_dst", exp_dst.size(), 0);
        chk("left_err", exp_err.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
